pipe_scoreboard: RTL

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It generalises fixed load-use detection to execution units with variable result latency (ALU, load, multi-cycle mul/div). It tracks a per-register countdown of cycles until each pending result is available. From that state it decides stall, forwarding and issue for the instruction in ID, and it rolls back the reservation of an instruction killed in EX by a taken branch.

---
 rtl/pipe_scoreboard_if.sv | 37 +++
 rtl/pipe_scoreboard.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard_if.sv
// Issue/hazard interface between the ID stage and pipe_scoreboard.
// master: ID-stage control (drives the issue slot and kill_ex, receives
//         stall/issue_fire/forward selects/busy vector).
// slave : the scoreboard itself.
interface pipe_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1),
    parameter int unsigned RA_W     = $clog2(NUM_REGS)
);
    logic                issue_valid;
    logic [RA_W-1:0]     issue_rd;
    logic                issue_regwrite;
    logic [LAT_W-1:0]    issue_lat;
    logic [RA_W-1:0]     issue_rs1;
    logic [RA_W-1:0]     issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    logic                kill_ex;
    logic                stall;
    logic                issue_fire;
    logic                fwd_rs1;
    logic                fwd_rs2;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output issue_valid, issue_rd, issue_regwrite, issue_lat,
               issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, kill_ex,
        input  stall, issue_fire, fwd_rs1, fwd_rs2, busy_vec
    );

    modport slave (
        input  issue_valid, issue_rd, issue_regwrite, issue_lat,
               issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, kill_ex,
        output stall, issue_fire, fwd_rs1, fwd_rs2, busy_vec
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register latency countdown scoreboard deciding stall,
// forwarding and issue for the instruction in ID, with rollback of the
// reservation made by an instruction killed in EX.
//
// Ports:
//   clock        single clock domain
//   reset        synchronous, active-high
//   sb (slave)   issue slot in (valid, rd, regwrite, lat, rs1/rs2, use flags,
//                kill_ex); stall/issue_fire out (combinational), fwd_rs1/
//                fwd_rs2 and busy_vec out (registered)
//
// Build option: define PIPE_SCOREBOARD_FWD_EN to enable the bypass path
// (consumers may issue when the producer is two cycles out). Without it,
// consumers wait until the value is in the register file and fwd_* stay 0.
module pipe_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1),
    parameter int unsigned RA_W     = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    pipe_scoreboard_if.slave sb
);

    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic                li_valid_q;
    logic [RA_W-1:0]     li_rd_q;
    logic [LAT_W-1:0]    li_prev_q;
    logic                fwd_rs1_q;
    logic                fwd_rs2_q;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [LAT_W-1:0]    lat_eff;
    logic [LAT_W-1:0]    c1;
    logic [LAT_W-1:0]    c2;
    logic                chk1;
    logic                chk2;
    logic                haz1;
    logic                haz2;
    logic                fwd1_c;
    logic                fwd2_c;
    logic                waw;
    logic                live;
    logic                stall_c;
    logic                fire_c;
    logic                reserve;

    // Hazard evaluation for the ID instruction.
    always_comb begin
        lat_eff = sb.issue_lat;
        if (sb.issue_lat == '0) begin
            lat_eff = LAT_W'(1);
        end else if (32'(sb.issue_lat) > MAX_LAT) begin
            lat_eff = LAT_W'(MAX_LAT);
        end

        c1   = cnt_q[sb.issue_rs1];
        c2   = cnt_q[sb.issue_rs2];
        chk1 = sb.issue_use_rs1 && (sb.issue_rs1 != '0);
        chk2 = sb.issue_use_rs2 && (sb.issue_rs2 != '0);
`ifdef PIPE_SCOREBOARD_FWD_EN
        haz1   = chk1 && (32'(c1) >= 32'd3);
        haz2   = chk2 && (32'(c2) >= 32'd3);
        fwd1_c = chk1 && (32'(c1) == 32'd2);
        fwd2_c = chk2 && (32'(c2) == 32'd2);
`else
        haz1   = chk1 && (32'(c1) >= 32'd2);
        haz2   = chk2 && (32'(c2) >= 32'd2);
        fwd1_c = 1'b0;
        fwd2_c = 1'b0;
`endif
        // An older, slower write must not land after this younger one.
        waw = sb.issue_regwrite && (sb.issue_rd != '0) &&
              (cnt_q[sb.issue_rd] > lat_eff);

        live    = sb.issue_valid && !sb.kill_ex;
        stall_c = live && (haz1 || haz2 || waw);
        fire_c  = live && !stall_c;
        reserve = fire_c && sb.issue_regwrite && (sb.issue_rd != '0);
    end

    // Counter update: age, then roll back a killed reservation, then reserve.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        if (sb.kill_ex && li_valid_q) begin
            // Killed instruction's previous value, aged over both cycles.
            cnt_d[li_rd_q] = (li_prev_q > LAT_W'(1)) ? li_prev_q - LAT_W'(2) : '0;
        end
        if (reserve) begin
            cnt_d[sb.issue_rd] = lat_eff;
        end
        cnt_d[0] = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            li_valid_q <= 1'b0;
            li_rd_q    <= '0;
            li_prev_q  <= '0;
            fwd_rs1_q  <= 1'b0;
            fwd_rs2_q  <= 1'b0;
            busy_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            li_valid_q <= reserve;
            li_rd_q    <= sb.issue_rd;
            li_prev_q  <= cnt_q[sb.issue_rd];
            fwd_rs1_q  <= fire_c && fwd1_c;
            fwd_rs2_q  <= fire_c && fwd2_c;
            busy_q     <= busy_d;
        end
    end

    assign sb.stall      = stall_c;
    assign sb.issue_fire = fire_c;
    assign sb.fwd_rs1    = fwd_rs1_q;
    assign sb.fwd_rs2    = fwd_rs2_q;
    assign sb.busy_vec   = busy_q;

endmodule
